load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter: MEM_WORDS, 64, data-memory depth in 32-bit words; the legal byte-address range is 0 .. 4*MEM_WORDS-1.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: req_valid  input  1  core request present.
REQ-005 The block SHALL have port: req_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port: req_op  input  3  op: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 SB, 111 SH, 011 SW.
REQ-007 The block SHALL have port: req_addr  input  32  byte address.
REQ-008 The block SHALL have port: req_wdata  input  32  store data; SB uses bits 7:0 and SH uses bits 15:0.
REQ-009 The block SHALL have port: resp_valid  output  1  response present.
REQ-010 The block SHALL have port: resp_ready  input  1  core accepts response.
REQ-011 The block SHALL have port: resp_data  output  32  load result; 0 for stores and errors.
REQ-012 The block SHALL have port: resp_err  output  1  misaligned or out-of-range request.
REQ-013 The block SHALL have ports: MemRead  output  1, MemWrite  output  1, addr  output  32 (word index), write_data  output  32, read_data  input  32 (combinational read of word addr, valid while MemRead=1; memory commits writes on the falling clk edge while MemWrite=1).

Function
REQ-014 The block SHALL implement FSM states IDLE, RD, WR, RESP, with req_ready=1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge with state IDLE and req_valid=1; op, addr and wdata SHALL be registered and then held constant until return to IDLE.
REQ-016 On acceptance, an error request (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0; any addr >= 4*MEM_WORDS) SHALL go to RESP with resp_err=1, resp_data=0 and no memory strobe.
REQ-017 On acceptance, a legal load, SB or SH SHALL go to RD, and SW SHALL go to WR.
REQ-018 In RD, MemRead SHALL be 1 and addr SHALL be req_addr[31:2].
REQ-019 For loads, RD SHALL capture the extracted lane into resp_data (LB/LH sign-extended, LBU/LHU zero-extended, LW whole word) and go to RESP.
REQ-020 For SB/SH, RD SHALL capture the raw word into a merge register and go to WR.
REQ-021 In WR, MemWrite SHALL be 1 for exactly one cycle, addr SHALL be the word index, and write_data SHALL be req_wdata for SW or the captured word with the selected lane replaced for SB/SH; the state SHALL then go to RESP.
REQ-022 Byte lanes SHALL be little-endian: byte offset 0 is bits 7:0, offset 3 is bits 31:24, and halfword offset 2 is bits 31:16.
REQ-023 In RESP, resp_valid SHALL be 1 and resp_data/resp_err SHALL be stable until resp_ready=1 at a rising edge, after which the state SHALL go to IDLE.
REQ-024 A new request SHALL NOT be accepted in the same cycle a response completes.
REQ-025 MemRead and MemWrite SHALL never be 1 simultaneously, and both SHALL be 0 outside RD/WR respectively.
REQ-026 When both strobes are 0, addr and write_data SHALL be 0.
REQ-027 Accept-to-resp_valid latency SHALL be: errors 1 cycle; loads and SW 2 cycles; SB/SH 3 cycles.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, and req_ready SHALL be 1 while idle after reset.
REQ-029 rst=0 SHALL immediately force resp_valid=0, resp_data=0, resp_err=0, MemRead=0, MemWrite=0, addr=0, write_data=0, and clear the internal registers.
REQ-030 Reset asserted mid-transaction SHALL abort it with no MemWrite pulse afterwards; a pending SB/SH merge SHALL be discarded without partial write.

Verification
REQ-031 Case LW: memory word 5 = 0x8899AABB, LW addr 0x14 -> MemRead at cycle 1, resp_valid at cycle 2 with resp_data=0x8899AABB, resp_err=0.
REQ-032 Case LB/LBU: word 5 = 0x8899AABB, LB addr 0x17 -> 0xFFFFFF88; LBU addr 0x17 -> 0x00000088; LHU addr 0x14 -> 0x0000AABB.
REQ-033 Case SB: word 3 = 0x11223344, SB addr 0x0D wdata 0xFFFFFFEE -> one MemWrite with write_data=0x1122EE44; a subsequent LW 0x0C returns 0x1122EE44; resp_valid at cycle 3.
REQ-034 Case errors: LW 0x02 and SH 0x21 -> resp_err=1, resp_data=0, no MemRead/MemWrite; LW 0x100 with MEM_WORDS=64 -> resp_err=1.
REQ-035 Case backpressure: resp_ready held 0 for 4 cycles -> resp_valid/resp_data held stable, req_ready=0 throughout, and a concurrent req_valid is not accepted.
REQ-036 Case reset: rst pulsed low during RD of an SB -> outputs zero immediately, no MemWrite observed, target word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/halfword/word load-store unit with read-modify-write
//               sub-word stores against a single-ported word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    localparam logic [2:0]  c_OP_LB  = 3'b000;
    localparam logic [2:0]  c_OP_LH  = 3'b001;
    localparam logic [2:0]  c_OP_LW  = 3'b010;
    localparam logic [2:0]  c_OP_SW  = 3'b011;
    localparam logic [2:0]  c_OP_LBU = 3'b100;
    localparam logic [2:0]  c_OP_LHU = 3'b101;
    localparam logic [2:0]  c_OP_SB  = 3'b110;
    localparam logic [2:0]  c_OP_SH  = 3'b111;
    localparam logic [32:0] c_ADDR_LIMIT = 33'(4 * MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic        r_err;

    logic        w_req_err;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    function automatic logic f_is_half(input logic [2:0] op);
        return (op == c_OP_LH) || (op == c_OP_LHU) || (op == c_OP_SH);
    endfunction

    function automatic logic f_is_word(input logic [2:0] op);
        return (op == c_OP_LW) || (op == c_OP_SW);
    endfunction

    function automatic logic f_is_subword_store(input logic [2:0] op);
        return (op == c_OP_SB) || (op == c_OP_SH);
    endfunction

    always_comb begin
        w_req_err = ({1'b0, req_addr} >= c_ADDR_LIMIT)
                  || (f_is_half(req_op) && req_addr[0])
                  || (f_is_word(req_op) && (req_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        resp_valid = 1'b0;
        resp_data  = 32'h0;
        resp_err   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next = RESP;
                    end else if (req_op == c_OP_SW) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD: begin
                MemRead = 1'b1;
                addr    = {2'b00, r_addr[31:2]};
                w_next  = f_is_subword_store(r_op) ? WR : RESP;
            end
            WR: begin
                MemWrite   = 1'b1;
                addr       = {2'b00, r_addr[31:2]};
                write_data = w_merge;
                w_next     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = r_data;
                resp_err   = r_err;
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Little-endian lane selection from the registered byte offset
    always_comb begin
        w_shamt   = {r_addr[1:0], 3'b000};
        w_shifted = read_data >> w_shamt;
        w_byte    = w_shifted[7:0];
        w_half    = r_addr[1] ? read_data[31:16] : read_data[15:0];
        case (r_op)
            c_OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load = {24'h0, w_byte};
            c_OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load = {16'h0, w_half};
            default:  w_load = read_data;
        endcase
    end

    // r_data holds the word captured in RD while a sub-word store is in WR
    always_comb begin
        case (r_op)
            c_OP_SB: w_merge = (r_data & ~(32'h0000_00FF << w_shamt))
                             | ({24'h0, r_wdata[7:0]} << w_shamt);
            c_OP_SH: w_merge = r_addr[1] ? {r_wdata[15:0], r_data[15:0]}
                                         : {r_data[31:16], r_wdata[15:0]};
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_data  <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_data  <= 32'h0;
                        r_err   <= w_req_err;
                    end
                end
                RD:      r_data <= f_is_subword_store(r_op) ? read_data : w_load;
                WR:      r_data <= 32'h0;
                default: r_data <= r_data;
            endcase
        end
    end

endmodule
`default_nettype wire
